serial_sub_ctrl: RTL and testbench



---
 rtl/sub_pkg.sv | 17 +
 rtl/full_substractor.sv | 14 +
 rtl/serial_sub_ctrl.sv | 94 +++++++++
 tb/tb_serial_sub_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared constants for the bit-serial subtractor controller.
// Holds FSM state encodings and the default operand width.
package sub_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/full_substractor.sv
// One-bit full subtractor cell: diff = a - b - bin, bout = borrow.
// Ports: a, b, bin inputs; diff, bout outputs.
module full_substractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor, LSB first through one 1-bit cell.
// Ports: clk, rst_n, start, a_in, b_in -> busy, done, diff_out, borrow_out.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             cell_d;
  logic             cell_b;

  assign last = (cnt == CW'(WIDTH - 1));

  full_substractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .diff (cell_d),
    .bout (cell_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
    end else if (state == S_IDLE && start) begin
      a_sh <= a_in;
      b_sh <= b_in;
      res  <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (state == S_RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      res  <= {cell_d, res[WIDTH-1:1]};
      brw  <= cell_b;
      cnt  <= cnt + 1'b1;
      // publish only the complete word, never partial bits
      if (last) begin
        diff_out   <= {cell_d, res[WIDTH-1:1]};
        borrow_out <= cell_b;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl at WIDTH=8 and WIDTH=3.
// Random and directed operands checked against plain modular arithmetic.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8;
  logic [7:0] diff8;
  logic       borrow8;
  logic       start3;
  logic [2:0] a3, b3;
  logic       busy3, done3;
  logic [2:0] diff3;
  logic       borrow3;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] last_diff;
  logic       last_brw;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_sub_ctrl #(.WIDTH(8)) u8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start8),
    .a_in       (a8),
    .b_in       (b8),
    .busy       (busy8),
    .done       (done8),
    .diff_out   (diff8),
    .borrow_out (borrow8)
  );

  serial_sub_ctrl #(.WIDTH(3)) u3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start3),
    .a_in       (a3),
    .b_in       (b3),
    .busy       (busy3),
    .done       (done3),
    .diff_out   (diff3),
    .borrow_out (borrow3)
  );

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    start8 = 1'b0;
    start3 = 1'b0;
    a8 = 8'hA5; b8 = 8'h5A;
    a3 = 3'd5;  b3 = 3'd2;
    tick;
    tick;
    checks++;
    if ({busy8, done8, diff8, borrow8} !== 11'b0) begin
      errors++;
      $display("FAIL reset8 busy=%b done=%b diff=%h brw=%b required all 0",
               busy8, done8, diff8, borrow8);
    end
    checks++;
    if ({busy3, done3, diff3, borrow3} !== 6'b0) begin
      errors++;
      $display("FAIL reset3 busy=%b done=%b diff=%h brw=%b required all 0",
               busy3, done3, diff3, borrow3);
    end
    rst_n     = 1'b1;
    last_diff = 8'h00;
    last_brw  = 1'b0;
    tick;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input string name);
    logic [7:0] ed;
    logic       eb;
    ed = a - b;
    eb = (a < b);
    a8 = a; b8 = b; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0 ||
          diff8 !== last_diff || borrow8 !== last_brw) begin
        errors++;
        $display("FAIL %s run j=%0d busy=%b done=%b diff=%h brw=%b required 1 0 %h %b",
                 name, j, busy8, done8, diff8, borrow8, last_diff, last_brw);
      end
      tick;
    end
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b1 ||
        diff8 !== ed || borrow8 !== eb) begin
      errors++;
      $display("FAIL %s done busy=%b done=%b diff=%h brw=%b required 0 1 %h %b",
               name, busy8, done8, diff8, borrow8, ed, eb);
    end
    tick;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 ||
        diff8 !== ed || borrow8 !== eb) begin
      errors++;
      $display("FAIL %s hold busy=%b done=%b diff=%h brw=%b required 0 0 %h %b",
               name, busy8, done8, diff8, borrow8, ed, eb);
    end
    last_diff = ed;
    last_brw  = eb;
  endtask

  task automatic test_directed;
    run8(8'h5A, 8'h3C, "d5a_3c");
    run8(8'h3C, 8'h5A, "d3c_5a");
    run8(8'h00, 8'h01, "d00_01");
    run8(8'hFF, 8'hFF, "dff_ff");
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++)
      run8(8'($urandom), 8'($urandom), "rand");
  endtask

  task automatic test_ignore_start;
    int dones;
    dones = 0;
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      start8 = (j == 3 || j == 9);
      if (start8) begin
        a8 = 8'h00; b8 = 8'hFF;
      end
      tick;
      start8 = 1'b0;
      if (done8 === 1'b1) dones++;
      if (j == 8) begin
        checks++;
        if (done8 !== 1'b1 || diff8 !== 8'h0F || borrow8 !== 1'b0) begin
          errors++;
          $display("FAIL ignore_done done=%b diff=%h brw=%b required 1 0f 0",
                   done8, diff8, borrow8);
        end
      end
      if (j == 10) begin
        checks++;
        if (busy8 !== 1'b0) begin
          errors++;
          $display("FAIL ignore_done_start busy=%b required 0", busy8);
        end
      end
    end
    checks++;
    if (dones != 1 || diff8 !== 8'h0F || borrow8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_count dones=%0d diff=%h brw=%b required 1 0f 0",
               dones, diff8, borrow8);
    end
    last_diff = 8'h0F;
    last_brw  = 1'b0;
  endtask

  task automatic test_reset_mid;
    int dones;
    int busys;
    dones = 0;
    busys = 0;
    a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    for (int j = 0; j < 4; j++) tick;
    rst_n = 1'b0;
    tick;
    checks++;
    if ({busy8, done8, diff8, borrow8} !== 11'b0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b diff=%h brw=%b required all 0",
               busy8, done8, diff8, borrow8);
    end
    rst_n     = 1'b1;
    last_diff = 8'h00;
    last_brw  = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tick;
      if (done8 === 1'b1) dones++;
      if (busy8 === 1'b1) busys++;
    end
    checks++;
    if (dones != 0 || busys != 0 || diff8 !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_after dones=%0d busys=%0d diff=%h required 0 0 00",
               dones, busys, diff8);
    end
    run8(8'h5A, 8'h3C, "post_reset");
  endtask

  task automatic test_back_to_back3;
    int         prev;
    int         t;
    logic [5:0] kv;
    logic [2:0] a, b, ed;
    logic       eb;
    prev   = -1;
    start3 = 1'b1;
    for (int k = 0; k < 64; k++) begin
      kv = 6'(k);
      a  = kv[5:3];
      b  = kv[2:0];
      ed = 3'(a - b);
      eb = (a < b);
      a3 = a; b3 = b;
      t  = 0;
      while (busy3 !== 1'b1 && t < 10) begin
        tick;
        t++;
      end
      a3 = 3'($urandom);
      b3 = 3'($urandom);
      t  = 0;
      while (done3 !== 1'b1 && t < 10) begin
        tick;
        t++;
      end
      checks++;
      if (done3 !== 1'b1 || diff3 !== ed || borrow3 !== eb) begin
        errors++;
        $display("FAIL b2b3 a=%0d b=%0d done=%b diff=%0d brw=%b required 1 %0d %b",
                 a, b, done3, diff3, borrow3, ed, eb);
      end
      if (prev >= 0) begin
        checks++;
        if (cyc - prev != 5) begin
          errors++;
          $display("FAIL b2b3_spacing k=%0d got %0d required 5", k, cyc - prev);
        end
      end
      prev = cyc;
      if (done3 !== 1'b1) break;
    end
    start3 = 1'b0;
    tick;
    tick;
    tick;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_ignore_start;
    test_reset_mid;
    test_random;
    test_back_to_back3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
